trigger_generator: RTL

- Transmit side of the sTGC trigger line. Generates trigger pulses that the downstream trigger receiver can capture.
- Pulses come from a software request, a programmable periodic source, or a counted burst.
- Each pulse has a programmable width. A gap after each pulse guarantees the receiver re-arms, which takes two cycle_ticks after a pulse.
- trigger_out is single-ended and registered. The top level drives it through the differential output buffer.

---
 rtl/trigger_gen_pkg.sv | 23 ++
 rtl/trigger_generator.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/trigger_gen_pkg.sv
// Shared types and constants for the sTGC trigger-line generator.
// Optional macro TRIGGER_GEN_ALIGN_EN is consumed by trigger_generator.sv.
package trigger_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PULSE,
        GAP
    } state_t;

    localparam logic [1:0] MODE_SINGLE   = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_BURST    = 2'b10;

    // The receiver needs this many readout ticks after a pulse to re-arm.
    localparam int MIN_GAP_TICKS = 2;

    localparam int DEF_PERIOD_W = 24;
    localparam int DEF_WIDTH_W  = 10;
    localparam int DEF_INDEX_W  = 8;

endpackage

// File: rtl/trigger_generator.sv
// Transmit side of the sTGC trigger line: single, periodic and burst pulses.
// Define TRIGGER_GEN_ALIGN_EN to hold ARM until a readout cycle_tick.
module trigger_generator
    import trigger_gen_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int WIDTH_W  = DEF_WIDTH_W,
    parameter int INDEX_W  = DEF_INDEX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_gen,
    input  logic [1:0]          mode,
    input  logic                soft_trigger,
    input  logic [PERIOD_W-1:0] period,
    input  logic [WIDTH_W-1:0]  pulse_width,
    input  logic [INDEX_W-1:0]  burst_len,
    input  logic                cycle_tick,
    output logic                trigger_out,
    output logic [INDEX_W-1:0]  trigger_index,
    output logic                busy
);

    state_t              state;
    logic                soft_q;
    logic [1:0]          mode_l;
    logic [PERIOD_W-1:0] period_l;
    logic [WIDTH_W-1:0]  width_l;
    logic [INDEX_W-1:0]  burst_rem;
    logic [PERIOD_W-1:0] per_cnt;
    logic [WIDTH_W-1:0]  pw_cnt;
    logic [1:0]          tick_cnt;

    logic [PERIOD_W-1:0] per_next;
    logic [1:0]          tick_next;
    logic                gap_done;
    logic                start_req;
    logic                arm_ready;

    // Gap exit is judged on the values being written this edge, so a tick on
    // the deciding edge counts and pulse starts land exactly one period apart.
    assign per_next  = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
    assign tick_next = (cycle_tick && tick_cnt != 2'(MIN_GAP_TICKS)) ? tick_cnt + 1'b1 : tick_cnt;
    assign gap_done  = (per_next >= period_l) && (tick_next == 2'(MIN_GAP_TICKS));

    always_comb begin
        start_req = 1'b0;
        if (enable_gen) begin
            case (mode)
                MODE_PERIODIC: start_req = 1'b1;
                MODE_BURST:    start_req = soft_q && (burst_len != '0);
                default:       start_req = soft_q;
            endcase
        end
    end

`ifdef TRIGGER_GEN_ALIGN_EN
    logic align_hit;

    // Only ticks sampled while already in ARM count; the entry edge is excluded
    // because state is not yet ARM when it is sampled.
    always_ff @(posedge clk) begin
        if (rst || state != ARM) align_hit <= 1'b0;
        else if (cycle_tick)     align_hit <= 1'b1;
    end

    assign arm_ready = align_hit;
`else
    assign arm_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            soft_q        <= 1'b0;
            mode_l        <= MODE_SINGLE;
            period_l      <= '0;
            width_l       <= '0;
            burst_rem     <= '0;
            per_cnt       <= '0;
            pw_cnt        <= '0;
            tick_cnt      <= '0;
            trigger_out   <= 1'b0;
            trigger_index <= '0;
            busy          <= 1'b0;
        end else begin
            // Requests are only captured while idle, so nothing is queued.
            soft_q <= soft_trigger && (state == IDLE);

            case (state)
                IDLE: begin
                    if (start_req) begin
                        mode_l    <= (mode == MODE_PERIODIC || mode == MODE_BURST) ? mode : MODE_SINGLE;
                        period_l  <= period;
                        width_l   <= (pulse_width == '0) ? WIDTH_W'(1) : pulse_width;
                        burst_rem <= burst_len;
                        busy      <= 1'b1;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    if (arm_ready) begin
                        trigger_out   <= 1'b1;
                        trigger_index <= trigger_index + 1'b1;
                        per_cnt       <= PERIOD_W'(1);
                        pw_cnt        <= width_l;
                        tick_cnt      <= '0;
                        state         <= PULSE;
                    end
                end
                PULSE: begin
                    per_cnt <= per_next;
                    pw_cnt  <= pw_cnt - 1'b1;
                    if (pw_cnt == WIDTH_W'(1)) begin
                        trigger_out <= 1'b0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    per_cnt  <= per_next;
                    tick_cnt <= tick_next;
                    if (gap_done) begin
                        case (mode_l)
                            MODE_PERIODIC: begin
                                if (enable_gen) begin
                                    state <= ARM;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                            MODE_BURST: begin
                                burst_rem <= burst_rem - 1'b1;
                                if (enable_gen && burst_rem != INDEX_W'(1)) begin
                                    state <= ARM;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                            default: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
